tt_bnn_xnor_accum: RTL and testbench

//  Parametrised bitwise-logic MAC for the MNIST binarised datapath; successor to the single-cycle AND tile.

---
 rtl/tt_bnn_pkg.sv | 35 +++
 rtl/tt_bnn_xnor_accum_popcount.sv | 16 +
 rtl/tt_bnn_xnor_accum.sv | 150 +++++++++++++++
 tb/tb_tt_bnn_xnor_accum.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_bnn_pkg.sv
// Shared types and the per-beat bitwise operator for the binarised MAC tile.
package tt_bnn_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_XNOR = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_OR   = 2'b11
    } mode_e;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_e;

    // Widest word bitop handles; callers zero-extend and truncate the result.
    localparam int unsigned BITOP_MAX_W = 64;

    function automatic logic [BITOP_MAX_W-1:0] bitop(
        input mode_e                  mode,
        input logic [BITOP_MAX_W-1:0] a,
        input logic [BITOP_MAX_W-1:0] w
    );
        logic [BITOP_MAX_W-1:0] r;
        case (mode)
            MODE_AND:  r = a & w;
            MODE_XNOR: r = ~(a ^ w);
            MODE_XOR:  r = a ^ w;
            MODE_OR:   r = a | w;
            default:   r = a & w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tt_bnn_xnor_accum_popcount.sv
// Combinational population count of a W-bit word.
module tt_popcount #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);
    localparam int unsigned CW = $clog2(W+1);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end
endmodule

// File: rtl/tt_bnn_xnor_accum.sv
// Bitwise-op/popcount MAC over BEATS beats with saturating accumulator and threshold.
// Optional popcount pipeline register: define TT_BNN_POPCNT_PIPE_EN.
module tt_bnn_xnor_accum
    import tt_bnn_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BEATS  = 98,
    parameter int unsigned ACC_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] wgt,
    input  logic [ACC_W-1:0]  thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_bit,
    output logic              out_sat
);
    localparam int unsigned PC_W  = $clog2(DATA_W+1);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS-1);

    state_e            state, state_nx;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ACC_W-1:0]  acc;
    logic              sat;
    mode_e             frame_mode, beat_mode;
    logic [DATA_W-1:0] beat_bits;
    logic [PC_W-1:0]   beat_pc;
    logic              beat_acc, last_acc;
    logic              add_en, add_last;
    logic [PC_W-1:0]   add_pc;
    logic [ACC_W:0]    acc_sum;
    logic              hs_out, latch_res;

    // The first beat of a frame uses the live mode; later beats use the copy taken then.
    assign beat_mode = (beat_cnt == '0) ? mode_e'(mode) : frame_mode;
    assign beat_bits = DATA_W'(bitop(beat_mode, BITOP_MAX_W'(act), BITOP_MAX_W'(wgt)));

    tt_popcount #(.W(DATA_W)) u_popcount (
        .bits  (beat_bits),
        .count (beat_pc)
    );

    assign beat_acc = in_valid & in_ready & ~clear;
    assign last_acc = beat_acc & (beat_cnt == LAST_BEAT);

`ifdef TT_BNN_POPCNT_PIPE_EN
    logic            pipe_valid, pipe_last;
    logic [PC_W-1:0] pipe_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
            pipe_pc    <= '0;
        end else if (clear) begin
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
        end else if (ena) begin
            pipe_valid <= beat_acc;
            pipe_last  <= last_acc;
            pipe_pc    <= beat_pc;
        end
    end

    assign add_en   = pipe_valid & ena & ~clear;
    assign add_pc   = pipe_pc;
    assign add_last = pipe_last;
    assign in_ready = ena & (state == S_ACC) & ~(pipe_valid & pipe_last);
`else
    assign add_en   = beat_acc;
    assign add_pc   = beat_pc;
    assign add_last = last_acc;
    assign in_ready = ena & (state == S_ACC);
`endif

    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(add_pc);
    assign hs_out    = ena & ~clear & (state == S_OUT) & out_valid & out_ready;
    assign latch_res = ena & ~clear & (state == S_OUT) & ~out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_ACC;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = S_ACC;
        end else if (ena) begin
            case (state)
                S_ACC:   if (add_en & add_last) state_nx = S_OUT;
                S_OUT:   if (out_valid & out_ready) state_nx = S_ACC;
                default: state_nx = S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            acc        <= '0;
            sat        <= 1'b0;
            frame_mode <= MODE_AND;
        end else if (clear | hs_out) begin
            beat_cnt <= '0;
            acc      <= '0;
            sat      <= 1'b0;
        end else begin
            if (beat_acc) begin
                beat_cnt <= last_acc ? '0 : beat_cnt + CNT_W'(1);
                if (beat_cnt == '0) frame_mode <= beat_mode;
            end
            if (add_en) begin
                if (acc_sum > {1'b0, ACC_MAX}) begin
                    acc <= ACC_MAX;
                    sat <= 1'b1;
                end else begin
                    acc <= acc_sum[ACC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_bit   <= 1'b0;
            out_sat   <= 1'b0;
        end else if (clear | hs_out) begin
            out_valid <= 1'b0;
        end else if (latch_res) begin
            out_valid <= 1'b1;
            out_sum   <= acc;
            out_bit   <= (acc >= thresh);
            out_sat   <= sat;
        end
    end

endmodule

// File: tb/tb_tt_bnn_xnor_accum.sv
// Self-checking bench: directed frames plus randomized traffic against a frame-level model.
module tb_tt_bnn_xnor_accum;
    localparam int NB = 4;
`ifdef TT_BNN_POPCNT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, clear = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] act = 8'd0, wgt = 8'd0;
    logic [5:0] thresh = 6'd0;

    logic       in_ready_a, out_valid_a, out_bit_a, out_sat_a;
    logic [5:0] out_sum_a;
    logic       in_ready_b, out_valid_b, out_bit_b, out_sat_b;
    logic [3:0] out_sum_b;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    tt_bnn_xnor_accum #(.DATA_W(8), .BEATS(NB), .ACC_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_a), .act(act), .wgt(wgt),
        .thresh(thresh), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_bit(out_bit_a), .out_sat(out_sat_a)
    );

    tt_bnn_xnor_accum #(.DATA_W(8), .BEATS(NB), .ACC_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_b), .act(act), .wgt(wgt),
        .thresh(thresh[3:0]), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_bit(out_bit_b), .out_sat(out_sat_b)
    );

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act_v, exp_v, $time);
        end
    endtask

    function automatic int opcount(input int m, input logic [7:0] a, input logic [7:0] w);
        logic [7:0] r;
        case (m)
            0:       r = a & w;
            1:       r = ~(a ^ w);
            2:       r = a ^ w;
            default: r = a | w;
        endcase
        return $countones(r);
    endfunction

    // Frame-level model: collect BEATS popcounts, wait LAT enabled cycles, present result.
    typedef enum {P_COL, P_WAIT, P_PRES} phase_t;
    phase_t ph = P_COL, n_ph;
    int nb = 0, sum = 0, cnt = 0, m_mode = 0;
    int n_nb, n_sum, n_cnt, n_mode;
    int e_sum_a = 0, e_bit_a = 0, e_sat_a = 0, e_sum_b = 0, e_bit_b = 0, e_sat_b = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= P_COL; nb <= 0; sum <= 0;
        end else if (clear) begin
            ph <= P_COL; nb <= 0; sum <= 0;
        end else if (ena) begin
            n_ph = ph; n_nb = nb; n_sum = sum; n_cnt = cnt; n_mode = m_mode;
            case (ph)
                P_COL: if (in_valid) begin
                    if (nb == 0) n_mode = int'(mode);
                    n_sum = sum + opcount(n_mode, act, wgt);
                    n_nb  = nb + 1;
                    if (n_nb == NB) begin n_ph = P_WAIT; n_cnt = LAT; end
                end
                P_WAIT: begin
                    n_cnt = cnt - 1;
                    if (n_cnt == 0) begin
                        n_ph = P_PRES;
                        e_sum_a <= (sum > 63) ? 63 : sum;
                        e_sat_a <= (sum > 63) ? 1 : 0;
                        e_bit_a <= (((sum > 63) ? 63 : sum) >= int'(thresh)) ? 1 : 0;
                        e_sum_b <= (sum > 15) ? 15 : sum;
                        e_sat_b <= (sum > 15) ? 1 : 0;
                        e_bit_b <= (((sum > 15) ? 15 : sum) >= int'(thresh[3:0])) ? 1 : 0;
                    end
                end
                P_PRES: if (out_ready) begin n_ph = P_COL; n_nb = 0; n_sum = 0; end
                default: n_ph = P_COL;
            endcase
            ph <= n_ph; nb <= n_nb; sum <= n_sum; cnt <= n_cnt; m_mode <= n_mode;
        end
    end

    always @(negedge clk) begin
        chk("in_ready_a", 32'(in_ready_a), 32'(ena && ph == P_COL));
        chk("in_ready_b", 32'(in_ready_b), 32'(ena && ph == P_COL));
        chk("out_valid_a", 32'(out_valid_a), 32'(ph == P_PRES));
        chk("out_valid_b", 32'(out_valid_b), 32'(ph == P_PRES));
        if (ph == P_PRES) begin
            chk("out_sum_a", 32'(out_sum_a), 32'(e_sum_a));
            chk("out_bit_a", 32'(out_bit_a), 32'(e_bit_a));
            chk("out_sat_a", 32'(out_sat_a), 32'(e_sat_a));
            chk("out_sum_b", 32'(out_sum_b), 32'(e_sum_b));
            chk("out_bit_b", 32'(out_bit_b), 32'(e_bit_b));
            chk("out_sat_b", 32'(out_sat_b), 32'(e_sat_b));
        end
    end

    task automatic send_beat(input logic [1:0] m, input logic [7:0] a, input logic [7:0] w);
        int n = 0;
        mode = m; act = a; wgt = w; in_valid = 1'b1;
        while (!in_ready_a && n < 50) begin @(posedge clk); #1; n++; end
        chk("beat_accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int es_a, input int eb_a, input int esat_a,
                               input int es_b, input int eb_b, input int esat_b);
        int n = 0;
        while (!out_valid_a && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
        chk({tag, "_sum_a"}, 32'(out_sum_a), 32'(es_a));
        chk({tag, "_bit_a"}, 32'(out_bit_a), 32'(eb_a));
        chk({tag, "_sat_a"}, 32'(out_sat_a), 32'(esat_a));
        chk({tag, "_sum_b"}, 32'(out_sum_b), 32'(es_b));
        chk({tag, "_bit_b"}, 32'(out_bit_b), 32'(eb_b));
        chk({tag, "_sat_b"}, 32'(out_sat_b), 32'(esat_b));
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid_a), 32'd0);
        chk({tag, "_ready_rise"}, 32'(in_ready_a), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_sum", 32'(out_sum_a), 32'd0);
        chk("rst_out_bit", 32'(out_bit_a), 32'd0);
        chk("rst_out_sat", 32'(out_sat_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);

        // 1: XNOR all-ones
        thresh = 6'd16;
        repeat (4) send_beat(2'b01, 8'hFF, 8'hFF);
        wait_result("t1", 32, 1, 0, 15, 1, 1);
        take_result("t1");

        // 2: AND F0/3C
        thresh = 6'd9;
        repeat (4) send_beat(2'b00, 8'hF0, 8'h3C);
        wait_result("t2", 8, 0, 0, 8, 0, 0);
        take_result("t2");

        // 3: mode change after first beat is ignored
        thresh = 6'd10;
        send_beat(2'b10, 8'h0F, 8'hFF);
        repeat (3) send_beat(2'b11, 8'h0F, 8'hFF);
        wait_result("t3", 16, 1, 0, 15, 1, 1);
        take_result("t3");

        // 4: backpressure hold, then fresh frame
        thresh = 6'd9;
        repeat (4) send_beat(2'b00, 8'hF0, 8'h3C);
        wait_result("t4a", 8, 0, 0, 8, 0, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("t4_hold_ready", 32'(in_ready_a), 32'd0);
            chk("t4_hold_sum", 32'(out_sum_a), 32'd8);
            chk("t4_hold_valid", 32'(out_valid_a), 32'd1);
        end
        in_valid = 1'b0;
        take_result("t4");
        repeat (4) send_beat(2'b00, 8'hF0, 8'h3C);
        wait_result("t4b", 8, 0, 0, 8, 0, 0);
        take_result("t4b");

        // 5: clear mid-frame drops partial sum and the beat presented with it
        thresh = 6'd16;
        repeat (2) send_beat(2'b01, 8'hFF, 8'hFF);
        in_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        repeat (4) send_beat(2'b01, 8'hFF, 8'hFF);
        wait_result("t5", 32, 1, 0, 15, 1, 1);
        take_result("t5");

        // 5b: async reset mid-frame and with a result pending
        repeat (2) send_beat(2'b01, 8'hFF, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_mid_ready", 32'(in_ready_a), 32'd1);
        chk("t5_rst_mid_valid", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) send_beat(2'b01, 8'hFF, 8'hFF);
        wait_result("t5c", 32, 1, 0, 15, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_res_valid", 32'(out_valid_a), 32'd0);
        chk("t5_rst_res_ready", 32'(in_ready_a), 32'd1);
        chk("t5_rst_res_sum", 32'(out_sum_a), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // randomized traffic; the model and per-cycle compare do the checking
        for (int c = 0; c < 600; c++) begin
            ena       = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = 2'($urandom_range(0, 3));
            act       = 8'($urandom);
            wgt       = 8'($urandom);
            thresh    = 6'($urandom);
            @(posedge clk); #1;
        end
        ena = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
